life_field_store: RTL and testbench

Parametrised generation store for the Game of Life datapath. Holds the current and previous field, accepts new generations from the next-state logic through a valid/ready handshake, and supports run, pause, single-step and synchronous reload of the start pattern. It counts generations and flags still-life, period-2 oscillation and extinction so the controller can auto-halt.

---
 rtl/life_field_store.sv | 151 +++++++++++++++
 tb/tb_life_field_store.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_field_store.sv
// Generation store for the Game of Life datapath: holds current/previous field, accepts new
// generations over valid/ready, and flags still-life, period-2 oscillation and extinction.
module life_field_store #(
    parameter int unsigned W     = 40,
    parameter int unsigned H     = 30,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     field_start_i [H],
    input  logic             load_start_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             auto_halt_i,
    input  logic             new_vld_i,
    output logic             new_rdy_o,
    input  logic [W-1:0]     field_new_i [H],
    output logic [W-1:0]     field_cur_o [H],
    output logic [W-1:0]     field_prev_o [H],
    output logic [GEN_W-1:0] gen_count_o,
    output logic             stable_o,
    output logic             osc2_o,
    output logic             extinct_o
);

    typedef enum logic [1:0] {
        StPaused,
        StRunning,
        StStep
    } state_e;

    state_e           state_q;
    logic             rdy_q;

    logic [W-1:0]     field_cur_q  [H];
    logic [W-1:0]     field_prev_q [H];
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [1:0]       hist_q, hist_d;
    logic             stable_q, stable_d;
    logic             osc2_q, osc2_d;

    logic [H-1:0]     row_eq_cur;
    logic [H-1:0]     row_eq_prev;
    logic [H-1:0]     row_zero;
    logic             eq_cur;
    logic             eq_prev;
    logic             accept;
    logic             halt_hit;

    // Row-wise compares keep each equality check a narrow W-bit reduction.
    always_comb begin
        row_eq_cur  = '0;
        row_eq_prev = '0;
        row_zero    = '0;
        for (int r = 0; r < int'(H); r++) begin
            row_eq_cur[r]  = (field_new_i[r] == field_cur_q[r]);
            row_eq_prev[r] = (field_new_i[r] == field_prev_q[r]);
            row_zero[r]    = (field_cur_q[r] == '0);
        end
    end

    assign eq_cur  = &row_eq_cur;
    assign eq_prev = &row_eq_prev;

    assign accept   = new_vld_i & rdy_q & ~load_start_i;
    assign stable_d = eq_cur;
    assign osc2_d   = (hist_q >= 2'd1) & eq_prev & ~eq_cur;
    assign halt_hit = stable_d | osc2_d;

    always_comb begin
        gen_d  = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);
        hist_d = (hist_q >= 2'd2) ? 2'd2 : hist_q + 2'd1;
    end

    // Control FSM; new_rdy is registered alongside the state so it never depends on new_vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPaused;
            rdy_q   <= 1'b0;
        end else if (load_start_i) begin
            state_q <= StPaused;
            rdy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StPaused: begin
                    if (run_i) begin
                        state_q <= StRunning;
                        rdy_q   <= 1'b1;
                    end else if (step_i) begin
                        state_q <= StStep;
                        rdy_q   <= 1'b1;
                    end
                end
                StRunning: begin
                    if (!run_i || (accept && auto_halt_i && halt_hit)) begin
                        state_q <= StPaused;
                        rdy_q   <= 1'b0;
                    end
                end
                StStep: begin
                    if (accept) begin
                        state_q <= run_i ? StRunning : StPaused;
                        rdy_q   <= run_i;
                    end else if (run_i) begin
                        state_q <= StRunning;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StPaused;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Reset loads the start pattern asynchronously so the field is valid straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_cur_q  <= field_start_i;
            field_prev_q <= '{default: '0};
            gen_q        <= '0;
            hist_q       <= 2'd0;
            stable_q     <= 1'b0;
            osc2_q       <= 1'b0;
        end else if (load_start_i) begin
            field_cur_q  <= field_start_i;
            field_prev_q <= '{default: '0};
            gen_q        <= '0;
            hist_q       <= 2'd0;
            stable_q     <= 1'b0;
            osc2_q       <= 1'b0;
        end else if (accept) begin
            field_prev_q <= field_cur_q;
            field_cur_q  <= field_new_i;
            gen_q        <= gen_d;
            hist_q       <= hist_d;
            stable_q     <= stable_d;
            osc2_q       <= osc2_d;
        end
    end

    assign new_rdy_o    = rdy_q;
    assign field_cur_o  = field_cur_q;
    assign field_prev_o = field_prev_q;
    assign gen_count_o  = gen_q;
    assign stable_o     = stable_q;
    assign osc2_o       = osc2_q;
    assign extinct_o    = &row_zero;

endmodule

// File: tb/tb_life_field_store.sv
// Scoreboard bench for life_field_store: stimulus pushes the expected post-accept state,
// a monitor pops and compares on every observed handshake.
module tb_life_field_store;

    localparam int unsigned W     = 40;
    localparam int unsigned H     = 30;
    localparam int unsigned GEN_W = 4;

    typedef logic [W-1:0] field_t [H];
    typedef logic [H-1:0][W-1:0] pfield_t;
    typedef struct packed {
        pfield_t          cur;
        pfield_t          prev;
        logic [GEN_W-1:0] gen;
        logic             stable;
        logic             osc2;
        logic             extinct;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    field_t           field_start;
    logic             load_start;
    logic             run;
    logic             step;
    logic             auto_halt;
    logic             new_vld;
    logic             new_rdy;
    field_t           field_new;
    field_t           field_cur;
    field_t           field_prev;
    logic [GEN_W-1:0] gen_count;
    logic             stable;
    logic             osc2;
    logic             extinct;

    exp_t   sb_q [$];
    exp_t   mon_e;
    logic   mon_hs;
    int     n_tests = 0;
    int     n_fail  = 0;
    field_t f_zero, f_bh, f_bv, f_block;

    life_field_store #(
        .W    (W),
        .H    (H),
        .GEN_W(GEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .field_start_i(field_start),
        .load_start_i (load_start),
        .run_i        (run),
        .step_i       (step),
        .auto_halt_i  (auto_halt),
        .new_vld_i    (new_vld),
        .new_rdy_o    (new_rdy),
        .field_new_i  (field_new),
        .field_cur_o  (field_cur),
        .field_prev_o (field_prev),
        .gen_count_o  (gen_count),
        .stable_o     (stable),
        .osc2_o       (osc2),
        .extinct_o    (extinct)
    );

    always #5 clk = ~clk;

    function automatic pfield_t pack(input field_t f);
        pfield_t p;
        for (int r = 0; r < int'(H); r++) p[r] = f[r];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_field(input string name, input pfield_t act, input pfield_t exp);
        int bad;
        bad = -1;
        for (int r = 0; r < int'(H); r++) if (bad < 0 && act[r] !== exp[r]) bad = r;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: row %0d got %h expected %h at %0t", name, bad, act[bad],
                     exp[bad], $time);
        end
    endtask

    task automatic push(input field_t cur, input field_t prev, input int gen, input bit st,
                        input bit o2, input bit ex);
        exp_t e;
        e.cur     = pack(cur);
        e.prev    = pack(prev);
        e.gen     = GEN_W'(gen);
        e.stable  = st;
        e.osc2    = o2;
        e.extinct = ex;
        sb_q.push_back(e);
    endtask

    // Monitor: a handshake seen at the edge must match the oldest expectation.
    always @(posedge clk) begin
        mon_hs = new_vld && new_rdy && !load_start && !rst;
        #1;
        if (mon_hs) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_accept: accept seen, none expected at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk_field("acc_cur", pack(field_cur), mon_e.cur);
                chk_field("acc_prev", pack(field_prev), mon_e.prev);
                chk("acc_gen", 32'(gen_count), 32'(mon_e.gen));
                chk("acc_stable", 32'(stable), 32'(mon_e.stable));
                chk("acc_osc2", 32'(osc2), 32'(mon_e.osc2));
                chk("acc_extinct", 32'(extinct), 32'(mon_e.extinct));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        f_zero = '{default: '0};
        f_bh = f_zero;
        f_bh[15][21:19] = 3'b111;
        f_bv = f_zero;
        f_bv[14][20] = 1'b1;
        f_bv[15][20] = 1'b1;
        f_bv[16][20] = 1'b1;
        f_block = f_zero;
        f_block[10][6:5] = 2'b11;
        f_block[11][6:5] = 2'b11;

        rst = 1'b1;
        field_start = f_bh;
        field_new = f_zero;
        load_start = 1'b0;
        run = 1'b0;
        step = 1'b0;
        auto_halt = 1'b0;
        new_vld = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_field("rst_cur", pack(field_cur), pack(f_bh));
        chk_field("rst_prev", pack(field_prev), pack(f_zero));
        chk("rst_rdy", 32'(new_rdy), 0);
        chk("rst_gen", 32'(gen_count), 0);
        chk("rst_extinct", 32'(extinct), 0);
        chk("rst_stable", 32'(stable), 0);
        chk("rst_osc2", 32'(osc2), 0);

        // Free run over blinker phases
        run = 1'b1;
        @(negedge clk);
        chk("run_rdy", 32'(new_rdy), 1);
        new_vld = 1'b1;
        field_new = f_bv;
        push(f_bv, f_bh, 1, 0, 0, 0);
        @(negedge clk);
        field_new = f_bh;
        push(f_bh, f_bv, 2, 0, 1, 0);
        @(negedge clk);
        field_new = f_bv;
        push(f_bv, f_bh, 3, 0, 1, 0);
        @(negedge clk);
        new_vld = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("pause_rdy", 32'(new_rdy), 0);
        chk("run_gen", 32'(gen_count), 3);

        // Single step
        field_start = f_bh;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("load_gen", 32'(gen_count), 0);
        chk("load_osc2", 32'(osc2), 0);
        chk_field("load_prev", pack(field_prev), pack(f_zero));
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step_rdy", 32'(new_rdy), 1);
        repeat (2) @(negedge clk);
        chk("step_wait_rdy", 32'(new_rdy), 1);
        new_vld = 1'b1;
        field_new = f_bv;
        push(f_bv, f_bh, 1, 0, 0, 0);
        @(negedge clk);
        chk("step_done_rdy", 32'(new_rdy), 0);
        @(negedge clk);
        new_vld = 1'b0;
        chk("step_gen", 32'(gen_count), 1);

        // Auto-halt on a still life
        field_start = f_block;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        auto_halt = 1'b1;
        run = 1'b1;
        @(negedge clk);
        new_vld = 1'b1;
        field_new = f_block;
        push(f_block, f_block, 1, 1, 0, 0);
        @(negedge clk);
        chk("halt_rdy", 32'(new_rdy), 0);
        chk("halt_gen", 32'(gen_count), 1);
        new_vld = 1'b0;
        run = 1'b0;
        auto_halt = 1'b0;
        @(negedge clk);

        // Load collides with a handshake while running
        run = 1'b1;
        @(negedge clk);
        chk("coll_rdy_before", 32'(new_rdy), 1);
        new_vld = 1'b1;
        field_new = f_bv;
        field_start = f_bh;
        load_start = 1'b1;
        @(negedge clk);
        chk_field("coll_cur", pack(field_cur), pack(f_bh));
        chk("coll_gen", 32'(gen_count), 0);
        chk("coll_rdy", 32'(new_rdy), 0);
        chk("coll_stable", 32'(stable), 0);
        load_start = 1'b0;
        new_vld = 1'b0;
        run = 1'b0;
        @(negedge clk);

        // Counter saturation, then extinction
        run = 1'b1;
        @(negedge clk);
        new_vld = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            field_new = (i % 2 == 1) ? f_bv : f_bh;
            if (i % 2 == 1) push(f_bv, f_bh, (i > 15) ? 15 : i, 0, i >= 2, 0);
            else            push(f_bh, f_bv, (i > 15) ? 15 : i, 0, i >= 2, 0);
            @(negedge clk);
        end
        field_new = f_zero;
        push(f_zero, f_bh, 15, 0, 0, 1);
        @(negedge clk);
        new_vld = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("sat_gen", 32'(gen_count), 15);
        chk("sat_extinct", 32'(extinct), 1);

        // Asynchronous reset mid-run drops the in-flight generation
        run = 1'b1;
        @(negedge clk);
        field_start = f_block;
        field_new = f_bv;
        new_vld = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_field("arst_cur", pack(field_cur), pack(f_block));
        chk("arst_rdy", 32'(new_rdy), 0);
        chk("arst_gen", 32'(gen_count), 0);
        @(negedge clk);
        rst = 1'b0;
        new_vld = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_extinct", 32'(extinct), 0);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
